regfile_alu_pipe: RTL and testbench
===================================

Name: regfile_alu_pipe

Overview:
Parametrised register file plus ALU execute unit for the RISC-V datapath, replacing the fixed 32x32 combinational register/ALU pair. It has two pipeline stages (issue/operand-read, execute/writeback), forwarding from writeback to issue, and a valid/ready issue handshake. An optional iterative multiplier adds a stall state machine. It sits between the decode/control unit and the data-memory stage.

Parameters:
XLEN, 32, datapath and register width
NUM_REGS, 32, register count; x0 is hardwired to zero
IMM_W, 12, immediate width, sign-extended to XLEN
AW, $clog2(NUM_REGS), register index width (derived; do not override)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  instruction presented this cycle
in_ready  out  1  unit can accept an instruction this cycle
rs1  in  AW  source register 1 index
rs2  in  AW  source register 2 index
rd  in  AW  destination register index
RegWrite  in  1  write result to rd
ALUSrc  in  1  operand B select: 1 = imm, 0 = rs2 value
ALUOp0  in  1  ALU op bit 0
ALUOp1  in  1  ALU op bit 1
func3  in  3  instruction funct3
func7  in  7  instruction funct7
imm  in  IMM_W  immediate
rv1  out  XLEN  registered operand A of the instruction in execute
rv2  out  XLEN  registered rs2 value (store data) of the instruction in execute
result  out  XLEN  registered ALU result
zero  out  1  registered (result == 0)
out_valid  out  1  result/zero valid; 1-cycle pulse per instruction

Behaviour:
- Reset: all registers are 0. rv1, rv2, result, zero = 0; out_valid = 0; in_ready = 1; FSM = IDLE; the pipeline holds no instruction.
- Accept: an instruction is accepted on a rising edge where in_valid && in_ready. Operands are read and captured into the EX register: A = R[rs1]; B = ALUSrc ? sext(imm) : R[rs2]; rv2 = R[rs2]. ALU op, rd and RegWrite are also captured.
- Reads of x0 always return 0.
- Execute: on the edge after acceptance, the ALU output is latched into result/zero and out_valid pulses for one cycle.
- Writeback: on that same edge, R[rd] is written if RegWrite && rd != 0. Writes to x0 are discarded.
- Latency: 2 edges from acceptance to out_valid. Throughput is one instruction per cycle for non-MUL ops.
- Forwarding: if an instruction is accepted on the same edge that a writeback to rd happens, and rs1 or rs2 equals that rd (rd != 0), the operand takes the forwarded ALU value instead of the stale register value.
- ALU decode on {ALUOp1,ALUOp0}:
  - 00: ADD.
  - 01: SUB.
  - 11: reserved; result = 0.
  - 10, by func3: 000 ADD, or SUB when func7[5] && !ALUSrc; 001 SLL; 010 SLT (signed); 011 SLTU; 100 XOR; 101 SRL, or SRA when func7[5]; 110 OR; 111 AND.
- Arithmetic is modulo 2^XLEN with overflow ignored. Shift amount is B[$clog2(XLEN)-1:0].
- in_valid low: the EX stage becomes a bubble. out_valid is 0 next cycle; result/zero hold their last values.
- Inputs are ignored while in_ready = 0.
- Reset asserted mid-operation aborts the in-flight instruction: no register write, and out_valid stays 0.

Optional Feature:
- Macro: REGFILE_ALU_MUL_EN.
- With the macro defined:
  - {ALUOp1,ALUOp0}=10, func3=000, func7=0000001 is MUL (low XLEN bits of A*B).
  - A MUL enters state MUL_BUSY for XLEN cycles of shift-add. One bit is retired per cycle.
  - in_ready = 0 from the edge after acceptance until the result edge.
  - out_valid pulses XLEN+1 edges after acceptance, and writeback happens on that same edge.
  - Forwarding to the next instruction applies as for single-cycle ops.
  - FSM states: IDLE -> EXEC (single-cycle op) or IDLE -> MUL_BUSY (MUL). MUL_BUSY -> IDLE when the bit count reaches XLEN.
- Without the macro: func7=0000001 decodes as ADD (func7[5] = 0), and in_ready is constantly 1.

Decomposition:
- Package alu_pkg holds:
  - ALUOp encodings.
  - func3 codes.
  - the func7 SUB/SRA bit index.
  - the MUL func7 constant.
  - the alu_op_e enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL, NOP).
  - the FSM state enum.
- Sub-module regfile: parametrised NUM_REGS x XLEN storage with two combinational read ports, one synchronous write port and an x0 guard.

Test Plan:
- Reset, then read x5 and x6 -> rv1 = rv2 = 0, in_ready = 1, out_valid = 0.
- ADDI x5,x0,7 (ALUSrc=1, imm=7, ALUOp=10, func3=000), then ADDI x6,x0,-3 (imm=12'hFFD) -> result=7, then result=32'hFFFFFFFD; out_valid pulses 2 edges after each accept.
- Back-to-back: ADD x7,x5,x6 issued the cycle after the x6 writeback, then SUB x8,x7,x5 immediately -> result=4, then result=32'hFFFFFFFD; exercises forwarding.
- ADDI x0,x0,9, then ADD x9,x0,x0 -> result 9 on the first, then x9 = 0 and zero = 1.
- SRA with x5=32'h80000000, imm=4, func7[5]=1 -> 32'hF8000000. SLTU with 1 vs 32'hFFFFFFFF -> 1. SLT on the same operands -> 0.
- With REGFILE_ALU_MUL_EN: MUL x10,x5,x6 with x5=6, x6=7 -> in_ready low for 32 cycles, result=42 at accept+33. Repeat, asserting reset at cycle 10 -> x10 unchanged at 0, out_valid never high.

Source files
------------

// File: rtl/regfile_alu_pipe_pkg.sv
// alu_pkg: encodings shared by the register-file/ALU execute unit.
// Holds the ALUOp/func3/func7 codes, the decoded ALU operation enum,
// the stall FSM state enum, and the instruction-to-operation decoder.
package alu_pkg;

   // {ALUOp1,ALUOp0} encodings
   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;
   localparam logic [1:0] ALUOP_RSVD = 2'b11;

   // func3 codes for ALUOp = FUNC
   localparam logic [2:0] F3_ADDSUB = 3'b000;
   localparam logic [2:0] F3_SLL    = 3'b001;
   localparam logic [2:0] F3_SLT    = 3'b010;
   localparam logic [2:0] F3_SLTU   = 3'b011;
   localparam logic [2:0] F3_XOR    = 3'b100;
   localparam logic [2:0] F3_SR     = 3'b101;
   localparam logic [2:0] F3_OR     = 3'b110;
   localparam logic [2:0] F3_AND    = 3'b111;

   // func7 bit selecting SUB/SRA, and the M-extension MUL pattern
   localparam int         F7_ALT_BIT = 5;
   localparam logic [6:0] F7_MUL     = 7'b0000001;

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
      OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MUL, OP_NOP
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE, ST_EXEC, ST_MUL_BUSY
   } state_e;

   // Map control bits to an ALU operation. MUL is only recognised for
   // register-register forms, so an I-type immediate whose upper bits
   // happen to look like 0000001 still decodes as ADDI.
   function automatic alu_op_e alu_decode(input logic [1:0] aluop,
                                          input logic [2:0] f3,
                                          input logic [6:0] f7,
                                          input logic       alusrc,
                                          input logic       mul_en);
      alu_op_e op;
      op = OP_NOP;
      case (aluop)
         ALUOP_ADD:  op = OP_ADD;
         ALUOP_SUB:  op = OP_SUB;
         ALUOP_FUNC: begin
            case (f3)
               F3_ADDSUB: begin
                  if (mul_en && !alusrc && (f7 == F7_MUL)) op = OP_MUL;
                  else if (f7[F7_ALT_BIT] && !alusrc)      op = OP_SUB;
                  else                                     op = OP_ADD;
               end
               F3_SLL:  op = OP_SLL;
               F3_SLT:  op = OP_SLT;
               F3_SLTU: op = OP_SLTU;
               F3_XOR:  op = OP_XOR;
               F3_SR:   op = f7[F7_ALT_BIT] ? OP_SRA : OP_SRL;
               F3_OR:   op = OP_OR;
               F3_AND:  op = OP_AND;
               default: op = OP_NOP;
            endcase
         end
         default: op = OP_NOP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/regfile_alu_pipe_regfile.sv
// regfile: NUM_REGS x XLEN register storage with two combinational read
// ports and one synchronous write port. x0 reads as zero and ignores writes.
module regfile #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int AW       = $clog2(NUM_REGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_we,
   input  logic [AW-1:0]   i_waddr,
   input  logic [XLEN-1:0] i_wdata,
   input  logic [AW-1:0]   i_raddr1,
   output logic [XLEN-1:0] o_rdata1,
   input  logic [AW-1:0]   i_raddr2,
   output logic [XLEN-1:0] o_rdata2
);

   logic [XLEN-1:0] r_mem [NUM_REGS];

   // Synchronous write; x0 and out-of-range indices are never written.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
      end else if (i_we && (i_waddr != '0) && (int'(i_waddr) < NUM_REGS)) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Combinational read ports with the x0 guard.
   always_comb begin
      o_rdata1 = '0;
      o_rdata2 = '0;
      if ((i_raddr1 != '0) && (int'(i_raddr1) < NUM_REGS)) o_rdata1 = r_mem[i_raddr1];
      if ((i_raddr2 != '0) && (int'(i_raddr2) < NUM_REGS)) o_rdata2 = r_mem[i_raddr2];
   end

endmodule

// File: rtl/regfile_alu_pipe.sv
// regfile_alu_pipe: two-stage register-file + ALU execute unit.
// Stage p1 holds the issued instruction's operands; the edge after issue
// latches the ALU result, pulses out_valid and writes back. Writeback is
// forwarded to an instruction issued on that same edge.
// Optional iterative shift-add multiplier with a stall FSM is enabled by
// defining REGFILE_ALU_MUL_EN.
module regfile_alu_pipe
   import alu_pkg::*;
#(
   parameter  int XLEN     = 32,
   parameter  int NUM_REGS = 32,
   parameter  int IMM_W    = 12,
   localparam int AW       = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [AW-1:0]    rs1,
   input  logic [AW-1:0]    rs2,
   input  logic [AW-1:0]    rd,
   input  logic             RegWrite,
   input  logic             ALUSrc,
   input  logic             ALUOp0,
   input  logic             ALUOp1,
   input  logic [2:0]       func3,
   input  logic [6:0]       func7,
   input  logic [IMM_W-1:0] imm,
   output logic [XLEN-1:0]  rv1,
   output logic [XLEN-1:0]  rv2,
   output logic [XLEN-1:0]  result,
   output logic             zero,
   output logic             out_valid
);

   localparam int SHW = $clog2(XLEN);
`ifdef REGFILE_ALU_MUL_EN
   localparam logic MUL_EN = 1'b1;
`else
   localparam logic MUL_EN = 1'b0;
`endif

   // issue-side wires
   logic                    w_accept;
   alu_op_e                 w_op_dec;
   logic signed [XLEN-1:0]  w_imm_ext;
   logic [XLEN-1:0]         w_rf1;
   logic [XLEN-1:0]         w_rf2;
   logic                    w_fwd;
   logic signed [XLEN-1:0]  w_opa;
   logic signed [XLEN-1:0]  w_rs2v;
   logic signed [XLEN-1:0]  w_opb;

   // execute-side wires
   logic                    w_busy;
   logic                    w_ex_done;
   logic [SHW-1:0]          w_shamt;
   logic signed [XLEN-1:0]  w_alu;
   logic [XLEN-1:0]         w_mul_res;

   // p1: instruction in execute
   logic                    r_vld_p1;
   logic signed [XLEN-1:0]  r_a_p1;
   logic signed [XLEN-1:0]  r_b_p1;
   logic [XLEN-1:0]         r_rv2_p1;
   alu_op_e                 r_op_p1;
   logic [AW-1:0]           r_rd_p1;
   logic                    r_we_p1;

   // p2: registered outputs
   logic                    r_vld_p2;
   logic [XLEN-1:0]         r_result_p2;
   logic                    r_zero_p2;

   assign w_accept  = in_valid && in_ready;
   assign w_op_dec  = alu_decode({ALUOp1, ALUOp0}, func3, func7, ALUSrc, MUL_EN);
   assign w_imm_ext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};

   // An op in execute completes on any edge where it is not stalled.
   assign w_ex_done = r_vld_p1 && !w_busy;

   // Forward the completing result to a same-edge issue; x0 never forwards.
   assign w_fwd  = w_ex_done && r_we_p1 && (r_rd_p1 != '0);
   assign w_opa  = (w_fwd && (rs1 == r_rd_p1)) ? w_alu : w_rf1;
   assign w_rs2v = (w_fwd && (rs2 == r_rd_p1)) ? w_alu : w_rf2;
   assign w_opb  = ALUSrc ? w_imm_ext : w_rs2v;

   regfile #(
      .XLEN     (XLEN),
      .NUM_REGS (NUM_REGS),
      .AW       (AW)
   ) u_regfile (
      .clk      (clk),
      .reset    (reset),
      .i_we     (w_ex_done && r_we_p1),
      .i_waddr  (r_rd_p1),
      .i_wdata  (w_alu),
      .i_raddr1 (rs1),
      .o_rdata1 (w_rf1),
      .i_raddr2 (rs2),
      .o_rdata2 (w_rf2)
   );

   // ---- issue -> execute boundary (p1) ----
   // Capture operands and control on accept; drop to a bubble after completion.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld_p1 <= 1'b0;
         r_a_p1   <= '0;
         r_b_p1   <= '0;
         r_rv2_p1 <= '0;
         r_op_p1  <= OP_NOP;
         r_rd_p1  <= '0;
         r_we_p1  <= 1'b0;
      end else if (w_accept) begin
         r_vld_p1 <= 1'b1;
         r_a_p1   <= w_opa;
         r_b_p1   <= w_opb;
         r_rv2_p1 <= w_rs2v;
         r_op_p1  <= w_op_dec;
         r_rd_p1  <= rd;
         r_we_p1  <= RegWrite;
      end else if (w_ex_done) begin
         r_vld_p1 <= 1'b0;
      end
   end

   assign w_shamt = r_b_p1[SHW-1:0];

   // ALU: combinational evaluation of the op held in execute.
   always_comb begin
      w_alu = '0;
      case (r_op_p1)
         OP_ADD:  w_alu = r_a_p1 + r_b_p1;
         OP_SUB:  w_alu = r_a_p1 - r_b_p1;
         OP_SLL:  w_alu = r_a_p1 << w_shamt;
         OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, (r_a_p1 < r_b_p1)};
         OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, ($unsigned(r_a_p1) < $unsigned(r_b_p1))};
         OP_XOR:  w_alu = r_a_p1 ^ r_b_p1;
         OP_SRL:  w_alu = r_a_p1 >> w_shamt;
         OP_SRA:  w_alu = r_a_p1 >>> w_shamt;
         OP_OR:   w_alu = r_a_p1 | r_b_p1;
         OP_AND:  w_alu = r_a_p1 & r_b_p1;
         OP_MUL:  w_alu = w_mul_res;
         default: w_alu = '0;
      endcase
   end

   // ---- execute -> writeback boundary (p2) ----
   // Latch result/zero on completion; out_valid is a one-cycle pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld_p2    <= 1'b0;
         r_result_p2 <= '0;
         r_zero_p2   <= 1'b0;
      end else begin
         r_vld_p2 <= w_ex_done;
         if (w_ex_done) begin
            r_result_p2 <= w_alu;
            r_zero_p2   <= (w_alu == '0);
         end
      end
   end

   assign rv1       = r_a_p1;
   assign rv2       = r_rv2_p1;
   assign result    = r_result_p2;
   assign zero      = r_zero_p2;
   assign out_valid = r_vld_p2;

`ifdef REGFILE_ALU_MUL_EN
   localparam int CNT_W = $clog2(XLEN + 1);

   state_e             r_state;
   state_e             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [XLEN-1:0]    r_mcand;
   logic [XLEN-1:0]    r_mplier;
   logic [XLEN-1:0]    r_acc;
   logic               w_cnt_done;
   logic               w_is_mul;

   assign w_is_mul   = (w_op_dec == OP_MUL);
   assign w_cnt_done = (r_cnt == CNT_W'(XLEN));
   // Stalled while bits remain; the final cycle lets the next op issue so
   // it can pick up the product through the forwarding path.
   assign w_busy     = (r_state == ST_MUL_BUSY) && !w_cnt_done;
   assign in_ready   = !w_busy;
   assign w_mul_res  = r_acc;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // FSM next state: issue selects EXEC or MUL_BUSY; MUL_BUSY exits once all bits retire.
   always_comb begin
      w_state_nxt = ST_IDLE;
      if (w_accept)                                   w_state_nxt = w_is_mul ? ST_MUL_BUSY : ST_EXEC;
      else if ((r_state == ST_MUL_BUSY) && !w_cnt_done) w_state_nxt = ST_MUL_BUSY;
   end

   // Shift-add multiplier: load on issue, retire one multiplier bit per stalled cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else if (w_accept && w_is_mul) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= w_opa;
         r_mplier <= w_opb;
      end else if (w_busy) begin
         if (r_mplier[0]) r_acc <= r_acc + r_mcand;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CNT_W'(1);
      end
   end
`else
   assign w_busy    = 1'b0;
   assign in_ready  = 1'b1;
   assign w_mul_res = '0;
`endif

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// tb_regfile_alu_pipe: directed vectors with hand-computed results for
// regfile_alu_pipe (default XLEN=32, NUM_REGS=32, IMM_W=12).
module tb_regfile_alu_pipe;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  rs1, rs2, rd;
   logic        RegWrite, ALUSrc, ALUOp0, ALUOp1;
   logic [2:0]  func3;
   logic [6:0]  func7;
   logic [11:0] imm;
   logic [31:0] rv1, rv2, result;
   logic        zero, out_valid;

   int n_chk;
   int n_err;

   regfile_alu_pipe dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rs1       (rs1),
      .rs2       (rs2),
      .rd        (rd),
      .RegWrite  (RegWrite),
      .ALUSrc    (ALUSrc),
      .ALUOp0    (ALUOp0),
      .ALUOp1    (ALUOp1),
      .func3     (func3),
      .func7     (func7),
      .imm       (imm),
      .rv1       (rv1),
      .rv2       (rv2),
      .result    (result),
      .zero      (zero),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic we, input logic src, input logic [1:0] op,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [11:0] im);
      in_valid = 1'b1;
      rd       = d;
      rs1      = s1;
      rs2      = s2;
      RegWrite = we;
      ALUSrc   = src;
      ALUOp1   = op[1];
      ALUOp0   = op[0];
      func3    = f3;
      func7    = f7;
      imm      = im;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   // Issue one instruction alone, wait for completion, compare result.
   task automatic run1(input string tag, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic src, input logic [1:0] op,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [11:0] im,
                       input logic [31:0] exp);
      drive(d, s1, s2, 1'b1, src, op, f3, f7, im);
      step();
      idle();
      step();
      check(tag, result, exp);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      reset = 1'b1;
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 3'b000, 7'h00, 12'h000);
      idle();
      repeat (3) step();
      check("rst_rv1",      rv1,       32'h0);
      check("rst_rv2",      rv2,       32'h0);
      check("rst_result",   result,    32'h0);
      check("rst_zero",     {31'b0, zero},      32'h0);
      check("rst_in_ready", {31'b0, in_ready},  32'h1);
      check("rst_out_vld",  {31'b0, out_valid}, 32'h0);
      reset = 1'b0;

      // read x5/x6 (no write)
      drive(5'd0, 5'd5, 5'd6, 1'b0, 1'b0, 2'b00, 3'b000, 7'h00, 12'h000);
      step();
      check("read_rv1",   rv1, 32'h0);
      check("read_rv2",   rv2, 32'h0);
      check("read_ov_lat", {31'b0, out_valid}, 32'h0);

      // ADDI x5,x0,7
      drive(5'd5, 5'd0, 5'd0, 1'b1, 1'b1, 2'b10, 3'b000, 7'h00, 12'd7);
      step();
      check("read_ov",   {31'b0, out_valid}, 32'h1);
      check("read_zero", {31'b0, zero},      32'h1);

      // ADDI x6,x0,-3
      drive(5'd6, 5'd0, 5'd0, 1'b1, 1'b1, 2'b10, 3'b000, 7'h00, 12'hFFD);
      step();
      check("addi7",    result, 32'd7);
      check("addi7_ov", {31'b0, out_valid}, 32'h1);

      // ADD x7,x5,x6 issued as x6 writes back
      drive(5'd7, 5'd5, 5'd6, 1'b1, 1'b0, 2'b10, 3'b000, 7'h00, 12'h000);
      step();
      check("addim3",    result, 32'hFFFFFFFD);
      check("fwd_rv1",   rv1,    32'd7);
      check("fwd_rv2",   rv2,    32'hFFFFFFFD);

      // SUB x8,x7,x5 issued as x7 writes back
      drive(5'd8, 5'd7, 5'd5, 1'b1, 1'b0, 2'b10, 3'b000, 7'h20, 12'h000);
      step();
      check("add_x7",    result, 32'd4);
      check("fwd2_rv1",  rv1,    32'd4);
      check("fwd2_rv2",  rv2,    32'd7);

      idle();
      step();
      check("sub_x8",    result, 32'hFFFFFFFD);
      check("sub_ov",    {31'b0, out_valid}, 32'h1);
      step();
      check("bubble_ov",   {31'b0, out_valid}, 32'h0);
      check("bubble_hold", result, 32'hFFFFFFFD);

      // x0 write discarded, not forwarded
      drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'b10, 3'b000, 7'h00, 12'd9);
      step();
      drive(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 2'b10, 3'b000, 7'h00, 12'h000);
      step();
      check("addi_x0", result, 32'd9);
      idle();
      step();
      check("x0_read",  result, 32'h0);
      check("x0_zero",  {31'b0, zero}, 32'h1);

      // shifts and compares
      run1("li1",   5'd12, 5'd0,  5'd0,  1'b1, 2'b10, 3'b000, 7'h00, 12'd1,   32'd1);
      run1("slli",  5'd5,  5'd12, 5'd0,  1'b1, 2'b10, 3'b001, 7'h00, 12'd31,  32'h80000000);
      run1("srai",  5'd13, 5'd5,  5'd0,  1'b1, 2'b10, 3'b101, 7'h20, 12'h404, 32'hF8000000);
      run1("srli",  5'd13, 5'd5,  5'd0,  1'b1, 2'b10, 3'b101, 7'h00, 12'h004, 32'h08000000);
      run1("li14",  5'd14, 5'd0,  5'd0,  1'b1, 2'b10, 3'b000, 7'h00, 12'd1,   32'd1);
      run1("li15",  5'd15, 5'd0,  5'd0,  1'b1, 2'b10, 3'b000, 7'h00, 12'hFFF, 32'hFFFFFFFF);
      run1("sltu",  5'd16, 5'd14, 5'd15, 1'b0, 2'b10, 3'b011, 7'h00, 12'h000, 32'd1);
      run1("slt",   5'd16, 5'd14, 5'd15, 1'b0, 2'b10, 3'b010, 7'h00, 12'h000, 32'd0);
      run1("slt_r", 5'd16, 5'd15, 5'd14, 1'b0, 2'b10, 3'b010, 7'h00, 12'h000, 32'd1);
      run1("xor",   5'd17, 5'd14, 5'd15, 1'b0, 2'b10, 3'b100, 7'h00, 12'h000, 32'hFFFFFFFE);
      run1("and",   5'd17, 5'd14, 5'd15, 1'b0, 2'b10, 3'b111, 7'h00, 12'h000, 32'd1);
      run1("or",    5'd17, 5'd14, 5'd0,  1'b0, 2'b10, 3'b110, 7'h00, 12'h000, 32'd1);
      run1("rsvd",  5'd17, 5'd14, 5'd15, 1'b0, 2'b11, 3'b000, 7'h00, 12'h000, 32'd0);
      run1("op01",  5'd17, 5'd14, 5'd15, 1'b0, 2'b01, 3'b000, 7'h00, 12'h000, 32'd2);
      run1("addi_f7", 5'd17, 5'd14, 5'd0, 1'b1, 2'b10, 3'b000, 7'h20, 12'd3,  32'd4);
`ifndef REGFILE_ALU_MUL_EN
      run1("f7_01_add", 5'd17, 5'd14, 5'd15, 1'b0, 2'b10, 3'b000, 7'h01, 12'h000, 32'd0);
`endif

      // reset aborts an in-flight op
      drive(5'd20, 5'd0, 5'd0, 1'b1, 1'b1, 2'b10, 3'b000, 7'h00, 12'd5);
      step();
      reset = 1'b1;
      idle();
      step();
      reset = 1'b0;
      check("abort_ov", {31'b0, out_valid}, 32'h0);
      step();
      check("abort_ov2", {31'b0, out_valid}, 32'h0);
      drive(5'd0, 5'd20, 5'd0, 1'b0, 1'b0, 2'b00, 3'b000, 7'h00, 12'h000);
      step();
      idle();
      check("abort_x20", rv1, 32'h0);
      step();

`ifdef REGFILE_ALU_MUL_EN
      begin
         int lo;
         int k;
         int seen;
         run1("li6", 5'd5, 5'd0, 5'd0, 1'b1, 2'b10, 3'b000, 7'h00, 12'd6, 32'd6);
         run1("li7", 5'd6, 5'd0, 5'd0, 1'b1, 2'b10, 3'b000, 7'h00, 12'd7, 32'd7);
         drive(5'd10, 5'd5, 5'd6, 1'b1, 1'b0, 2'b10, 3'b000, 7'h01, 12'h000);
         step();
         idle();
         lo = 0;
         k  = 0;
         while (!out_valid && k < 60) begin
            if (!in_ready) lo++;
            step();
            k++;
         end
         check("mul_stall",   lo,     32);
         check("mul_latency", k + 1,  34);
         check("mul_result",  result, 32'd42);

         reset = 1'b1;
         step();
         reset = 1'b0;
         run1("li6b", 5'd5, 5'd0, 5'd0, 1'b1, 2'b10, 3'b000, 7'h00, 12'd6, 32'd6);
         run1("li7b", 5'd6, 5'd0, 5'd0, 1'b1, 2'b10, 3'b000, 7'h00, 12'd7, 32'd7);
         drive(5'd10, 5'd5, 5'd6, 1'b1, 1'b0, 2'b10, 3'b000, 7'h01, 12'h000);
         step();
         idle();
         repeat (9) step();
         reset = 1'b1;
         step();
         reset = 1'b0;
         seen = 0;
         for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            step();
         end
         check("mul_abort_ov", seen, 0);
         drive(5'd0, 5'd10, 5'd0, 1'b0, 1'b0, 2'b00, 3'b000, 7'h00, 12'h000);
         step();
         idle();
         check("mul_abort_x10", rv1, 32'h0);
         step();
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
